// File: rtl/dspclk_seq.sv
// Startup and health sequencer for the DSP clock PLL: settles, checks the
// heartbeat, releases the DSP-chain reset, and re-sequences or faults on loss.
module dspclk_seq #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned MIN_EDGES     = 4,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       hb,
    output logic       dsp_reset,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 32'd1);
    localparam logic [7:0]  WIN_LAST    = 8'(WINDOW - 32'd1);
    localparam logic [7:0]  EDGE_GOAL   = 8'(MIN_EDGES);
    localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRIES);

    logic [2:0]  state_q, state_d;
    logic [15:0] settle_q, settle_d;
    logic [7:0]  win_q, win_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [1:0]  retry_q, retry_d;
    logic        lost_q, lost_d;
    logic        hb_q;
    logic        dsp_reset_q, ready_q, fault_q;
    logic        hb_edge_s;
    logic [7:0]  edge_sum_s;

    // Next-state and counter update for the sequencer.
    always_comb begin
        hb_edge_s  = hb ^ hb_q;
        edge_sum_s = (edge_cnt_q == 8'hFF) ? edge_cnt_q : edge_cnt_q + 8'd1;
        state_d    = state_q;
        settle_d   = settle_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        gap_d      = gap_q;
        retry_d    = retry_q;
        lost_d     = lost_q;
        if (!enable) begin
            state_d    = ST_IDLE;
            settle_d   = 16'd0;
            win_d      = 8'd0;
            edge_cnt_d = 8'd0;
            gap_d      = 8'd0;
            retry_d    = 2'd0;
            lost_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = 16'd0;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d    = ST_CHECK;
                        win_d      = 8'd0;
                        edge_cnt_d = 8'd0;
                    end else begin
                        settle_d = settle_q + 16'd1;
                    end
                end
                ST_CHECK: begin
                    // A qualifying edge beats the end of the window.
                    if (hb_edge_s && (edge_sum_s == EDGE_GOAL)) begin
                        state_d    = ST_RUN;
                        retry_d    = 2'd0;
                        gap_d      = 8'd0;
                        edge_cnt_d = edge_sum_s;
                    end else begin
                        if (hb_edge_s) begin
                            edge_cnt_d = edge_sum_s;
                        end else begin
                            edge_cnt_d = edge_cnt_q;
                        end
                        if (win_q == WIN_LAST) begin
                            if (retry_q == RETRY_MAX) begin
                                state_d = ST_FAULT;
                            end else begin
                                retry_d  = retry_q + 2'd1;
                                state_d  = ST_SETTLE;
                                settle_d = 16'd0;
                            end
                        end else begin
                            win_d = win_q + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (hb_edge_s) begin
                        gap_d = 8'd0;
                    end else if (gap_q == WIN_LAST) begin
                        lost_d   = 1'b1;
                        state_d  = ST_SETTLE;
                        settle_d = 16'd0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and outputs decoded from next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= 16'd0;
            win_q       <= 8'd0;
            edge_cnt_q  <= 8'd0;
            gap_q       <= 8'd0;
            retry_q     <= 2'd0;
            lost_q      <= 1'b0;
            hb_q        <= 1'b0;
            dsp_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            win_q       <= win_d;
            edge_cnt_q  <= edge_cnt_d;
            gap_q       <= gap_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            hb_q        <= hb;
            dsp_reset_q <= (state_d != ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

    assign state       = state_q;
    assign dsp_reset   = dsp_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign lock_lost   = lost_q;
    assign retry_count = retry_q;

endmodule
